// File: rtl/miner_pkg.sv
// Shared types and constants for the miner control path.
// Covers job framing, result status codes and the hash/target comparison.
package miner_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    CHECK,
    REPORT
  } miner_state_t;

  localparam logic [7:0] STATUS_FOUND   = 8'h01;
  localparam logic [7:0] STATUS_EXHAUST = 8'hFF;

  localparam int HDR_BYTES    = 76;
  localparam int NONCE_BYTES  = 4;
  localparam int TARGET_BYTES = 28;

  // The target covers the top 224 bits of the hash; the low word is implicit zero.
  // An exactly equal hash is not a hit.
  function automatic logic hash_below_target(input logic [255:0]                hash,
                                             input logic [8*TARGET_BYTES-1:0]   target);
    return hash < {target, 32'h0};
  endfunction

endpackage

// File: rtl/miner_rx_assembler.sv
// Collects received bytes into a job image, MSB-first.
// Discards a partial job on a framing error or after a long idle gap between bytes.
module miner_rx_assembler
  import miner_pkg::*;
#(
  parameter int JOB_BYTES   = HDR_BYTES + NONCE_BYTES + TARGET_BYTES,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_error,
  output logic [8*JOB_BYTES-1:0] job_data,
  output logic                   job_ready
);

  localparam int CNT_W = $clog2(JOB_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_reg;
  logic [TO_W-1:0]  idle_reg;
  logic             job_ready_reg;
  logic             shift_en;

  assign shift_en  = enable && rx_valid && !rx_error;
  assign job_ready = job_ready_reg;

  // Lane 0 holds the newest byte, so after a full job lane 0 is the last byte.
  genvar gi;
  generate
    for (gi = 0; gi < JOB_BYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst)        lane_reg <= '0;
          else if (shift_en) lane_reg <= rx_data;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst)        lane_reg <= '0;
          else if (shift_en) lane_reg <= g_lane[gi-1].lane_reg;
        end
      end
      assign job_data[8*gi +: 8] = lane_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg     <= '0;
      idle_reg      <= '0;
      job_ready_reg <= 1'b0;
    end else begin
      job_ready_reg <= 1'b0;
      if (!enable || rx_error) begin
        count_reg <= '0;
        idle_reg  <= '0;
      end else if (rx_valid) begin
        idle_reg <= '0;
        if (count_reg == CNT_W'(JOB_BYTES - 1)) begin
          count_reg     <= '0;
          job_ready_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (count_reg != '0) begin
        if (idle_reg == TO_W'(TIMEOUT_CYC - 1)) begin
          count_reg <= '0;
          idle_reg  <= '0;
        end else begin
          idle_reg <= idle_reg + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/miner_sequencer.sv
// Control FSM between the UART receiver, the SHA-256 core and the UART transmitter.
// It walks nonces from the job's start value until a hash beats the target or the nonce space runs out.
module miner_sequencer
  import miner_pkg::*;
#(
  parameter int JOB_BYTES   = HDR_BYTES + NONCE_BYTES + TARGET_BYTES,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_error,
  output logic [8*HDR_BYTES-1:0]   hdr_out,
  output logic [31:0]              nonce,
  output logic                     sha_start,
  input  logic                     sha_done,
  input  logic [255:0]             sha_hash,
  output logic [39:0]              tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     busy
);

  localparam int HDR_BITS = 8 * HDR_BYTES;
  localparam int TGT_BITS = 8 * TARGET_BYTES;

  miner_state_t            state_reg;
  logic [HDR_BITS-1:0]     hdr_reg;
  logic [31:0]             nonce_reg;
  logic [TGT_BITS-1:0]     target_reg;
  logic [255:0]            hash_reg;
  logic [39:0]             tx_data_reg;
  logic                    sha_start_reg;
  logic                    tx_start_reg;
  logic                    busy_reg;

  logic [8*JOB_BYTES-1:0]  job_data;
  logic                    job_ready;

  miner_rx_assembler #(
    .JOB_BYTES   (JOB_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx_assembler (
    .clk       (clk),
    .n_rst     (n_rst),
    .enable    (state_reg == LOAD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .job_data  (job_data),
    .job_ready (job_ready)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= LOAD;
      hdr_reg       <= '0;
      nonce_reg     <= '0;
      target_reg    <= '0;
      hash_reg      <= '0;
      tx_data_reg   <= '0;
      sha_start_reg <= 1'b0;
      tx_start_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sha_start_reg <= 1'b0;
      tx_start_reg  <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (job_ready) begin
            hdr_reg    <= job_data[8*JOB_BYTES-1 -: HDR_BITS];
            nonce_reg  <= job_data[TGT_BITS +: 32];
            target_reg <= job_data[TGT_BITS-1:0];
            busy_reg   <= 1'b1;
            state_reg  <= START;
          end
        end
        START: begin
          sha_start_reg <= 1'b1;
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (sha_done) begin
            hash_reg  <= sha_hash;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (hash_below_target(hash_reg, target_reg)) begin
            tx_data_reg <= {STATUS_FOUND, nonce_reg};
            state_reg   <= REPORT;
          end else if (nonce_reg == 32'hFFFF_FFFF) begin
            tx_data_reg <= {STATUS_EXHAUST, nonce_reg};
            state_reg   <= REPORT;
          end else begin
            nonce_reg <= nonce_reg + 32'd1;
            state_reg <= START;
          end
        end
        REPORT: begin
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign hdr_out   = hdr_reg;
  assign nonce     = nonce_reg;
  assign sha_start = sha_start_reg;
  assign tx_data   = tx_data_reg;
  assign tx_start  = tx_start_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_miner_sequencer.sv
// Directed bench for miner_sequencer: stub hash core answers a few cycles after each sha_start,
// expected results are hand-computed per job.
module tb_miner_sequencer;
  import miner_pkg::*;

  localparam int TIMEOUT_CYC = 2000;
  localparam int WAIT_BOUND  = 3000;
  localparam logic [223:0] TARGET = {16'hFFFF, 208'h0};

  logic           clk;
  logic           n_rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_error;
  logic [607:0]   hdr_out;
  logic [31:0]    nonce;
  logic           sha_start;
  logic           sha_done;
  logic [255:0]   sha_hash;
  logic [39:0]    tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int sha_count = 0;
  int tx_count  = 0;

  logic         stub_en;
  logic         hit_en;
  logic [31:0]  hit_nonce;
  logic         eq_en;
  logic [31:0]  eq_nonce;
  logic [607:0] exp_hdr;

  miner_sequencer #(
    .JOB_BYTES   (108),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .hdr_out   (hdr_out),
    .nonce     (nonce),
    .sha_start (sha_start),
    .sha_done  (sha_done),
    .sha_hash  (sha_hash),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sha_start) sha_count++;
    if (tx_start)  tx_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    if (hit_en && n == hit_nonce) return 256'h1;
    if (eq_en && n == eq_nonce)   return {TARGET, 32'h0};
    return '1;
  endfunction

  // Stub hash core: three cycles of latency after each start pulse.
  initial begin
    sha_done = 1'b0;
    sha_hash = '0;
    forever begin
      @(negedge clk);
      if (sha_start && stub_en) begin
        repeat (2) @(negedge clk);
        sha_hash = stub_hash(nonce);
        sha_done = 1'b1;
        @(negedge clk);
        sha_done = 1'b0;
      end
    end
  end

  function automatic logic [7:0] job_byte(input int i, input logic [31:0] n);
    logic [223:0] t;
    t = TARGET;
    if (i < 76)      return 8'(i) ^ 8'hA5;
    else if (i < 80) return n[8*(79-i) +: 8];
    else             return t[8*(107-i) +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] start);
    for (int i = 0; i < 108; i++) send_byte(job_byte(i, start), 1'b0);
  endtask

  task automatic check_hdr(input string tag);
    for (int i = 0; i < 19; i++)
      check($sformatf("%s hdr word %0d", tag, i), 64'(hdr_out[32*i +: 32]), 64'(exp_hdr[32*i +: 32]));
  endtask

  task automatic wait_tx(input string tag);
    int n;
    n = 0;
    while (!tx_start && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, " tx_start seen"}, 64'(tx_start), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [31:0] start,
                         input logic [39:0] exp_tx, input int exp_hashes);
    int sha_base, tx_base;
    sha_base = sha_count;
    tx_base  = tx_count;
    send_job(start);
    wait_tx(tag);
    check({tag, " tx_data"}, 64'(tx_data), 64'(exp_tx));
    check({tag, " hashes"}, 64'(sha_count - sha_base), 64'(exp_hashes));
    repeat (4) @(negedge clk);
    check({tag, " single tx_start"}, 64'(tx_count - tx_base), 64'd1);
    check({tag, " busy after report"}, 64'(busy), 64'd0);
    $display("job %s: start=%h tx_data=%h hashes=%0d", tag, start, tx_data, sha_count - sha_base);
  endtask

  initial begin
    int n;
    int sha_base;
    n_rst    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    tx_busy  = 1'b0;
    stub_en  = 1'b1;
    hit_en   = 1'b1;
    hit_nonce = 32'd5;
    eq_en    = 1'b0;
    eq_nonce = '0;
    for (int i = 0; i < 76; i++) exp_hdr[8*(75-i) +: 8] = 8'(i) ^ 8'hA5;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset sha_start", 64'(sha_start), 64'd0);
    check("reset tx_start", 64'(tx_start), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset nonce", 64'(nonce), 64'd0);
    check("reset tx_data", 64'(tx_data), 64'd0);
    check("reset hdr top", 64'(hdr_out[607:576]), 64'd0);
    check("reset hdr low", 64'(hdr_out[31:0]), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Load: latch, then sha_start one cycle later
    send_job(32'd5);
    @(negedge clk);
    check("load nonce", 64'(nonce), 64'd5);
    check("load sha_start not yet", 64'(sha_start), 64'd0);
    check("load busy", 64'(busy), 64'd1);
    check_hdr("load");
    @(negedge clk);
    check("load sha_start", 64'(sha_start), 64'd1);
    wait_tx("load");
    check("load tx_data", 64'(tx_data), 64'h01_0000_0005);
    $display("job load: start=00000005 tx_data=%h", tx_data);
    repeat (2) @(negedge clk);

    // Hit on nonce 7; bytes arriving mid-search must be dropped
    hit_nonce = 32'd7;
    fork
      run_job("hit", 32'd5, 40'h01_0000_0007, 3);
      begin
        repeat (112) @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(8'h5A, 1'b0);
      end
    join

    // Exhaustion
    hit_en = 1'b0;
    run_job("exhaust", 32'hFFFF_FFFE, 40'hFF_FFFF_FFFF, 2);
    check("exhaust nonce held", 64'(nonce), 64'hFFFF_FFFF);

    // Hash equal to target is a miss
    hit_en = 1'b1;
    hit_nonce = 32'd10;
    eq_en = 1'b1;
    eq_nonce = 32'd9;
    run_job("boundary", 32'd9, 40'h01_0000_000A, 2);
    eq_en = 1'b0;

    // Partial job discarded after TIMEOUT_CYC idle cycles
    for (int i = 0; i < 50; i++) send_byte(8'h33, 1'b0);
    repeat (TIMEOUT_CYC) @(negedge clk);
    hit_nonce = 32'd20;
    run_job("timeout", 32'd20, 40'h01_0000_0014, 1);
    check_hdr("timeout");

    // Framing error on byte 40 discards the partial job
    for (int i = 0; i < 40; i++) send_byte(8'h77, 1'b0);
    send_byte(8'h99, 1'b1);
    hit_nonce = 32'd30;
    run_job("rx_error", 32'd30, 40'h01_0000_001E, 1);
    check_hdr("rx_error");

    // tx_start held off while the transmitter is busy
    tx_busy = 1'b1;
    hit_nonce = 32'd40;
    sha_base = tx_count;
    send_job(32'd40);
    n = 0;
    while (tx_data !== 40'h01_0000_0028 && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check("handshake report reached", 64'(tx_data), 64'h01_0000_0028);
    repeat (100) @(negedge clk);
    check("handshake no tx_start while busy", 64'(tx_count - sha_base), 64'd0);
    check("handshake still busy", 64'(busy), 64'd1);
    tx_busy = 1'b0;
    wait_tx("handshake");
    $display("job handshake: start=00000028 tx_data=%h", tx_data);
    repeat (2) @(negedge clk);

    // Asynchronous reset while waiting on the core
    stub_en = 1'b0;
    hit_nonce = 32'd50;
    send_job(32'd50);
    n = 0;
    while (!sha_start && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check("reset-test sha_start seen", 64'(sha_start), 64'd1);
    n_rst = 1'b0;
    #1;
    check("async reset sha_start", 64'(sha_start), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset nonce", 64'(nonce), 64'd0);
    check("async reset tx_data", 64'(tx_data), 64'd0);
    check("async reset tx_start", 64'(tx_start), 64'd0);
    check("async reset hdr", 64'(hdr_out[607:576]), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    stub_en = 1'b1;
    @(negedge clk);
    hit_nonce = 32'd60;
    run_job("after reset", 32'd60, 40'h01_0000_003C, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
